image_stream_reader: RTL and testbench

//  Read side of the image BRAM: walks a range of image addresses, issues reads
//  (1-cycle read latency, en=1/we=0), and streams each 784-bit image downstream

---
 rtl/image_pkg.sv | 25 ++
 rtl/image_stream_reader_if.sv | 14 +
 rtl/image_skid_fifo.sv | 57 +++++
 rtl/image_stream_reader.sv | 117 +++++++++++
 tb/tb_image_stream_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// Shared widths, FSM encodings and FIFO entry layout for the image BRAM read path.
package image_pkg;

  localparam int unsigned ADDR_WIDTH  = 14;
  localparam int unsigned DATA_WIDTH  = 784;
  localparam int unsigned NUM_IMAGES  = 16384;
  localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] data;
  } image_entry_t;

  // Image address successor, wrapping at the top of the RAM.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(NUM_IMAGES - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/image_stream_reader_if.sv
// Valid/ready image stream from the BRAM reader to the classifier datapath.
interface image_stream_reader_if;
  import image_pkg::*;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] index;
  logic                  last;

  modport master (output valid, data, index, last, input  ready);
  modport slave  (input  valid, data, index, last, output ready);

endinterface

// File: rtl/image_skid_fifo.sv
// Two-entry FIFO holding captured images; head entry drives the stream directly.
module image_skid_fifo
  import image_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  image_entry_t din,
  output image_entry_t head,
  output logic         full,
  output logic         empty
);

  image_entry_t slot0;
  image_entry_t slot1;
  logic [1:0]   occ;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (occ != 2'd0);
  assign do_push = push & ((occ != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= din;
          else             slot1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign full  = (occ == 2'd2);
  assign empty = (occ == 2'd0);

endmodule

// File: rtl/image_stream_reader.sv
// Walks a range of image addresses, reads the BRAM and streams each image
// downstream, holding at most two images outstanding (buffered + in flight).
module image_stream_reader
  import image_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  first_addr,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  image_stream_reader_if.master  img,
  output logic                   busy,
  output logic                   done
);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_index;
  logic                   inflight_last;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [2:0]             occupancy;
  logic                   credit_ok;
  logic                   drain_ok;
  logic                   issue_last;
  image_entry_t           push_entry;
  image_entry_t           head;

  assign pop        = ~empty & img.ready;
  assign occupancy  = full ? 3'd2 : (empty ? 3'd0 : 3'd1);
  assign credit_ok  = (occupancy + 3'(inflight)) < (3'd2 + 3'(pop));
  assign issue_last = (remaining == COUNT_WIDTH'(1));
  // Buffer is empty next cycle and nothing is left to land.
  assign drain_ok   = ~inflight & (empty | (~full & pop));

  // Next state and read issue; zero-length runs pass through DRAIN so done
  // lands two cycles after start.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DRAIN : FETCH;
      end
      FETCH: begin
        if (credit_ok) begin
          ram_en = 1'b1;
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_ok) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      inflight       <= 1'b0;
      inflight_index <= '0;
      inflight_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);
      inflight <= ram_en;
      if (ram_en) begin
        inflight_index <= addr;
        inflight_last  <= issue_last;
        addr           <= next_addr(addr);
        remaining      <= remaining - COUNT_WIDTH'(1);
      end else if ((state == IDLE) && start) begin
        addr      <= first_addr;
        remaining <= count;
      end
    end
  end

  assign ram_we   = 1'b0;
  assign ram_addr = addr;

  assign push_entry.last  = inflight_last;
  assign push_entry.index = inflight_index;
  assign push_entry.data  = ram_dout;

  image_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign img.valid = ~empty;
  assign img.data  = head.data;
  assign img.index = head.index;
  assign img.last  = head.last;

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: table-driven runs plus random runs, checked
// against an address-sequence model of the expected image stream.
`timescale 1ns/1ps
module tb_image_stream_reader;
  import image_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ADDR_WIDTH-1:0]  first_addr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   ram_en;
  logic                   ram_we;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0]  ram_dout;
  logic                   busy;
  logic                   done;

  image_stream_reader_if img();

  image_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .img        (img),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] seed;

  typedef struct {
    logic [ADDR_WIDTH-1:0] first;
    int cnt;
    int ready_mode;    // 0: always ready, 1: 1,0,0 repeating, 2: random
    int restart_cyc;   // cycle to re-pulse start (-1: never)
    int exp_first_valid;
    int exp_done;      // -1: derive from last handshake only
  } vec_t;

  // RAM contents: a pseudo-random image per address.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    logic [31:0] h;
    v = '0;
    for (int i = 0; i < int'(DATA_WIDTH / 16); i++) begin
      h = ((32'(a) + 32'(i) * 32'd977) * 32'h9E37_79B1) ^ seed;
      v[i*16 +: 16] = h[23:8];
    end
    return v;
  endfunction

  always @(posedge clk) if (ram_en) ram_dout <= pattern(ram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DATA_WIDTH-1:0] act,
                            input logic [DATA_WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got low64 %0h expected low64 %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic run(input vec_t v);
    logic [ADDR_WIDTH-1:0] exp_q[$];
    logic [ADDR_WIDTH-1:0] e;
    logic [ADDR_WIDTH-1:0] hold_idx;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;
    int  issued = 0, accepted = 0, last_hs = -1, first_valid = -1, first_issue = -1;
    bit  finished = 0, stalled = 0;
    for (int k = 0; k < v.cnt; k++)
      exp_q.push_back(ADDR_WIDTH'((32'(v.first) + 32'(k)) % NUM_IMAGES));
    hold_idx = '0; hold_data = '0; hold_last = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; first_addr = v.first; count = COUNT_WIDTH'(v.cnt);
      end else begin
        start = (c == v.restart_cyc);
        first_addr = v.first + ADDR_WIDTH'(100);
        count = COUNT_WIDTH'(5);
      end
      case (v.ready_mode)
        0:       img.ready = 1'b1;
        1:       img.ready = (c % 3 == 0);
        default: img.ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (ram_en) begin
        issued++;
        if (first_issue < 0) first_issue = c;
      end
      if (img.valid && img.ready) accepted++;
      check("outstanding_le_2", 64'((issued - accepted) <= 2), 64'(1));
      check("busy", 64'(busy), 64'(c >= 1));
      if (stalled) begin
        check("stall_valid", 64'(img.valid), 64'(1));
        check("stall_index", 64'(img.index), 64'(hold_idx));
        check("stall_last", 64'(img.last), 64'(hold_last));
        check_data("stall_data", img.data, hold_data);
      end
      if (img.valid && first_valid < 0) first_valid = c;
      if (img.valid && img.ready) begin
        if (exp_q.size() == 0) begin
          check("extra_image_index", 64'(img.index), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("img_index", 64'(img.index), 64'(e));
          check("img_last", 64'(img.last), 64'(accepted == v.cnt));
          check_data("img_data", img.data, pattern(e));
          if (v.ready_mode == 0) check("handshake_cycle", 64'(c), 64'(v.exp_first_valid + accepted - 1));
        end
        last_hs = c;
      end
      stalled   = img.valid && !img.ready;
      hold_idx  = img.index;
      hold_data = img.data;
      hold_last = img.last;
      if (done) begin
        finished = 1;
        if (v.exp_done >= 0) check("done_cycle", 64'(c), 64'(v.exp_done));
        if (v.cnt > 0) check("done_after_last", 64'(c), 64'(last_hs + 1));
        check("images_accepted", 64'(accepted), 64'(v.cnt));
        check("reads_issued", 64'(issued), 64'(v.cnt));
        check("first_ram_en_cycle", 64'(first_issue), 64'((v.cnt > 0) ? 1 : -1));
        check("first_valid_cycle", 64'(first_valid), 64'(v.exp_first_valid));
        check("ram_we", 64'(ram_we), 64'(0));
      end
    end
    if (!finished) check("done_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_valid", 64'(img.valid), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_en"},    64'(ram_en),    64'(0));
    check({tag, "_ram_addr"},  64'(ram_addr),  64'(0));
    check({tag, "_valid"},     64'(img.valid), 64'(0));
    check({tag, "_index"},     64'(img.index), 64'(0));
    check({tag, "_last"},      64'(img.last),  64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_done"},      64'(done),      64'(0));
    check_data({tag, "_data"}, img.data, '0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    seed = $urandom;
    rst = 1'b1; start = 1'b0; first_addr = '0; count = '0; img.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    tbl[0] = '{14'd5,     4,  0, -1, 3, 7};
    tbl[1] = '{14'd16382, 4,  0, -1, 3, 7};
    tbl[2] = '{14'd0,     6,  1, -1, 3, -1};
    tbl[3] = '{14'd9,     0,  0, -1, -1, 2};
    tbl[4] = '{14'd40,    3,  0,  2, 3, 6};
    tbl[5] = '{14'd16383, 1,  0, -1, 3, 4};
    tbl[6] = '{14'd200,   10, 2,  4, 3, -1};
    for (int i = 0; i < 7; i++) run(tbl[i]);

    // Reset with one image buffered and one read in flight.
    @(posedge clk); #1;
    start = 1'b1; first_addr = 14'd100; count = 15'd8; img.ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_valid", 64'(img.valid), 64'(1));
    check("pre_rst_index", 64'(img.index), 64'(100));
    check("pre_rst_no_credit", 64'(ram_en), 64'(0));
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(img.valid), 64'(0));
      check("post_rst_ram_en", 64'(ram_en), 64'(0));
    end
    run('{14'd7, 3, 0, -1, 3, 6});

    for (int i = 0; i < 6; i++) begin
      rv.first           = ADDR_WIDTH'($urandom_range(0, NUM_IMAGES - 1));
      rv.cnt             = int'($urandom_range(0, 12));
      rv.ready_mode      = 2;
      rv.restart_cyc     = int'($urandom_range(1, 6));
      rv.exp_first_valid = (rv.cnt > 0) ? 3 : -1;
      rv.exp_done        = (rv.cnt == 0) ? 2 : -1;
      run(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
